// File: rtl/instruction_fetch_unit_if.sv
// Fetch-unit bus: ROM read port, decoder handshake, control and status.
// The master side is the fetch unit; the slave side is its environment.
interface instruction_fetch_unit_if #(
    parameter int unsigned ADDR_W  = 3,
    parameter int unsigned INSTR_W = 12
);
    logic               start;
    logic [ADDR_W-1:0]  imem_addr;
    logic [INSTR_W-1:0] imem_data;
    logic [INSTR_W-1:0] instr;
    logic               instr_valid;
    logic               instr_ready;
    logic               redirect;
    logic [ADDR_W-1:0]  redirect_addr;
    logic [ADDR_W-1:0]  pc;
    logic               halted;

    modport master (
        input  start, imem_data, instr_ready, redirect, redirect_addr,
        output imem_addr, instr, instr_valid, pc, halted
    );

    modport slave (
        output start, imem_data, instr_ready, redirect, redirect_addr,
        input  imem_addr, instr, instr_valid, pc, halted
    );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the PC, reads a zero-latency ROM and presents
// registered instructions to the decoder over a valid/ready handshake.
module instruction_fetch_unit #(
    parameter int unsigned       ADDR_W   = 3,
    parameter int unsigned       INSTR_W  = 12,
    parameter int unsigned       OPC_W    = 3,
    parameter logic [OPC_W-1:0]  HALT_OPC = 3'b111
) (
    input  logic                      clk,
    input  logic                      reset,
    instruction_fetch_unit_if.master  bus
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_HOLD  = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic               valid_q, valid_d;
    logic               halted_q, halted_d;
    logic               handshake;
    logic               halt_seen;

    assign handshake = valid_q & bus.instr_ready;
    assign halt_seen = (instr_q[INSTR_W-1 -: OPC_W] == HALT_OPC);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            pc_q     <= '0;
            instr_q  <= '0;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            valid_q  <= valid_d;
            halted_q <= halted_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        instr_d  = instr_q;
        valid_d  = valid_q;
        halted_d = halted_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    pc_d    = '0;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                if (bus.redirect) begin
                    valid_d = 1'b0;
                    pc_d    = bus.redirect_addr;
                end else begin
                    instr_d = bus.imem_data;
                    valid_d = 1'b1;
                    pc_d    = pc_q + 1'b1;
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                // Redirect wins over both a plain handshake and a HALT acceptance.
                if (bus.redirect) begin
                    valid_d = 1'b0;
                    pc_d    = bus.redirect_addr;
                    state_d = S_FETCH;
                end else if (handshake && halt_seen) begin
                    valid_d  = 1'b0;
                    halted_d = 1'b1;
                    state_d  = S_HALT;
                end else if (handshake) begin
                    instr_d = bus.imem_data;
                    pc_d    = pc_q + 1'b1;
                end
            end
            S_HALT: begin
                if (bus.start) begin
                    halted_d = 1'b0;
                    pc_d     = '0;
                    state_d  = S_FETCH;
                end
            end
            default: begin
                state_d  = S_IDLE;
                valid_d  = 1'b0;
                halted_d = 1'b0;
            end
        endcase
    end

    assign bus.imem_addr   = pc_q;
    assign bus.pc          = pc_q;
    assign bus.instr       = instr_q;
    assign bus.instr_valid = valid_q;
    assign bus.halted      = halted_q;
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: directed scenarios followed
// by random control traffic, all compared against a transaction-level model.
module tb_instruction_fetch_unit;
    localparam int unsigned ADDR_W  = 3;
    localparam int unsigned INSTR_W = 12;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    instruction_fetch_unit_if #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) bus ();

    instruction_fetch_unit #(
        .ADDR_W   (ADDR_W),
        .INSTR_W  (INSTR_W),
        .OPC_W    (3),
        .HALT_OPC (3'b111)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [INSTR_W-1:0] rom [8];
    assign bus.imem_data = rom[bus.imem_addr];

    // Model: a running flag, a pending-fetch bubble, and the word on offer.
    logic [ADDR_W-1:0]  m_pc;
    logic [INSTR_W-1:0] m_instr;
    logic               m_valid;
    logic               m_halted;
    logic               m_run;
    logic               m_bubble;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = '0; m_instr = '0; m_valid = 1'b0;
        m_halted = 1'b0; m_run = 1'b0; m_bubble = 1'b0;
    endtask

    task automatic model_edge();
        if (!m_run) begin
            if (bus.start) begin
                m_run = 1'b1; m_halted = 1'b0; m_pc = '0; m_bubble = 1'b1;
            end
        end else if (bus.redirect) begin
            m_valid = 1'b0; m_pc = bus.redirect_addr; m_bubble = 1'b1;
        end else if (m_bubble) begin
            m_instr = rom[m_pc]; m_valid = 1'b1; m_pc = m_pc + 3'd1; m_bubble = 1'b0;
        end else if (m_valid && bus.instr_ready) begin
            if (m_instr[11:9] == 3'b111) begin
                m_valid = 1'b0; m_halted = 1'b1; m_run = 1'b0;
            end else begin
                m_instr = rom[m_pc]; m_pc = m_pc + 3'd1;
            end
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, "_valid"},  16'(bus.instr_valid), 16'(m_valid));
        chk({tag, "_pc"},     16'(bus.pc),          16'(m_pc));
        chk({tag, "_addr"},   16'(bus.imem_addr),   16'(m_pc));
        chk({tag, "_halted"}, 16'(bus.halted),      16'(m_halted));
        if (m_valid) chk({tag, "_instr"}, 16'(bus.instr), 16'(m_instr));
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_model(tag);
    endtask

    task automatic drive(input logic st, input logic rdy, input logic rd, input logic [ADDR_W-1:0] ra);
        bus.start = st; bus.instr_ready = rdy; bus.redirect = rd; bus.redirect_addr = ra;
    endtask

    logic [INSTR_W-1:0] stream_exp [6];

    initial begin
        for (int i = 0; i < 8; i++) rom[i] = 12'h010 + 12'(i);
        rom[5] = 12'hE00;
        stream_exp[0] = 12'h010; stream_exp[1] = 12'h011; stream_exp[2] = 12'h012;
        stream_exp[3] = 12'h013; stream_exp[4] = 12'h014; stream_exp[5] = 12'hE00;

        // Reset and idle
        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 3'd0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check_model("reset");
        chk("reset_instr", 16'(bus.instr), 16'h000);
        drive(1'b0, 1'b0, 1'b1, 3'd4);
        for (int i = 0; i < 10; i++) step("idle");
        chk("idle_pc", 16'(bus.pc), 16'd0);

        // Streaming to HALT
        drive(1'b1, 1'b1, 1'b0, 3'd0);
        step("start");
        drive(1'b0, 1'b1, 1'b0, 3'd0);
        for (int i = 0; i < 6; i++) begin
            step("stream");
            chk("stream_word", 16'(bus.instr), 16'(stream_exp[i]));
        end
        step("halt");
        chk("halt_halted", 16'(bus.halted), 16'd1);
        chk("halt_valid",  16'(bus.instr_valid), 16'd0);
        chk("halt_pc",     16'(bus.pc), 16'd6);
        drive(1'b0, 1'b1, 1'b1, 3'd3);
        step("halt_redirect_ignored");

        // Backpressure
        drive(1'b1, 1'b0, 1'b0, 3'd0);
        step("restart");
        drive(1'b0, 1'b0, 1'b0, 3'd0);
        step("bp_first");
        drive(1'b0, 1'b1, 1'b0, 3'd0);
        step("bp_a");
        step("bp_b");
        drive(1'b1, 1'b0, 1'b0, 3'd0);
        for (int i = 0; i < 4; i++) begin
            step("bp_hold");
            chk("bp_instr", 16'(bus.instr), 16'h012);
            chk("bp_pc",    16'(bus.pc), 16'd3);
            drive(1'b0, 1'b0, 1'b0, 3'd0);
        end
        drive(1'b0, 1'b1, 1'b0, 3'd0);
        step("bp_release");
        chk("bp_next", 16'(bus.instr), 16'h013);
        step("to_014");
        step("to_e00");
        chk("pre_simul", 16'(bus.instr), 16'hE00);

        // Redirect coinciding with HALT acceptance
        drive(1'b0, 1'b1, 1'b1, 3'd2);
        step("simul");
        chk("simul_halted", 16'(bus.halted), 16'd0);
        chk("simul_valid",  16'(bus.instr_valid), 16'd0);
        drive(1'b0, 1'b1, 1'b0, 3'd0);
        step("simul_next");
        chk("simul_word", 16'(bus.instr), 16'h012);

        // Redirect with PC wrap
        drive(1'b0, 1'b1, 1'b1, 3'd1);
        step("rd_to1");
        drive(1'b0, 1'b1, 1'b0, 3'd0);
        step("rd_011");
        chk("rd_pre", 16'(bus.instr), 16'h011);
        drive(1'b0, 1'b1, 1'b1, 3'd6);
        step("rd");
        chk("rd_bubble", 16'(bus.instr_valid), 16'd0);
        drive(1'b0, 1'b1, 1'b0, 3'd0);
        step("rd_016");
        chk("rd_016_w", 16'(bus.instr), 16'h016);
        chk("rd_016_pc", 16'(bus.pc), 16'd7);
        step("rd_017");
        chk("rd_017_w", 16'(bus.instr), 16'h017);
        step("rd_wrap");
        chk("rd_wrap_w", 16'(bus.instr), 16'h010);
        chk("rd_wrap_pc", 16'(bus.pc), 16'd1);

        // Asynchronous reset between edges
        #2 reset = 1'b1;
        #1;
        chk("areset_valid", 16'(bus.instr_valid), 16'd0);
        chk("areset_pc",    16'(bus.pc), 16'd0);
        chk("areset_instr", 16'(bus.instr), 16'd0);
        model_reset();
        @(posedge clk);
        #1 reset = 1'b0;
        check_model("areset_hold");
        drive(1'b1, 1'b1, 1'b0, 3'd0);
        step("areset_start");
        drive(1'b0, 1'b1, 1'b0, 3'd0);
        step("areset_first");
        chk("areset_word", 16'(bus.instr), 16'h010);

        // Random control traffic
        for (int i = 0; i < 400; i++) begin
            drive(($urandom % 8) == 0, ($urandom % 4) != 0, ($urandom % 6) == 0,
                  3'($urandom_range(0, 7)));
            step("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
